// File: rtl/shift_add_mul4.sv
// shift_add_mul4: sequential 4x4 -> 8 unsigned shift-and-add multiplier.
// One partial product is accumulated per CALC cycle; four cycles per multiply
// unless the optional early-exit build is selected.
// Optional feature macro: SHIFT_ADD_EARLY_EXIT_EN -- leave CALC as soon as the
// remaining multiplier bits are all zero.
module shift_add_mul4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       ld,
    output logic [7:0] p,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  mcand_q, mcand_d;
    logic [3:0]  mplier_q, mplier_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  p_q, p_d;
    logic        done_q, done_d;
    logic        last_iter;
    logic [7:0]  partial;

    // Partial product for the current multiplier bit, weighted by iteration.
    always_comb begin
        partial = 8'h00;
        if (mplier_q[0]) begin
            partial = {4'b0000, mcand_q} << cnt_q;
        end
    end

    // Decide whether this CALC edge is the final iteration.
    always_comb begin
`ifdef SHIFT_ADD_EARLY_EXIT_EN
        // Higher multiplier bits all zero: further iterations would add nothing.
        last_iter = (cnt_q == 2'd3) || (mplier_q[3:1] == 3'b000);
`else
        last_iter = (cnt_q == 2'd3);
`endif
    end

    // Next-state and datapath update for the multiply sequence.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    p_d      = 8'h00;
                    cnt_d    = 2'd0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                p_d      = p_q + partial;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 2'd1;
                if (last_iter) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= 4'h0;
            mplier_q <= 4'h0;
            cnt_q    <= 2'd0;
            p_q      <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            done_q   <= done_d;
        end
    end

    // Outputs; ld lets the upstream operand registers capture with our start edge.
    always_comb begin
        ld   = (state_q == StIdle) && start && !rst;
        busy = (state_q != StIdle);
        done = done_q;
        p    = p_q;
    end

endmodule
